// File: rtl/codec_cfg_sequencer.sv
// WM8731 configuration sequencer: walks the register table through the I2C frame transmitter with retry, then serves runtime writes.
// Optional macro CODEC_CFG_SOFT_RESET_EN prepends a codec soft-reset write (16'h1E00) to the table.
module codec_cfg_sequencer #(
    parameter logic [7:0]  DEV_ADDR       = 8'h34,
    parameter int unsigned SETTLE_CYCLES  = 50000,
    parameter int unsigned GAP_CYCLES     = 2500,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned RETRY_MAX      = 3
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    output logic [23:0] o_i2c_data,
    output logic        o_i2c_go,
    input  logic        i_i2c_end,
    input  logic        i_i2c_ack,
    input  logic        i_restart,
    input  logic        i_wr_valid,
    input  logic [6:0]  i_wr_addr,
    input  logic [8:0]  i_wr_data,
    output logic        o_wr_ready,
    output logic        o_busy,
    output logic        o_config_done,
    output logic        o_error,
    output logic [3:0]  o_index
);

`ifdef CODEC_CFG_SOFT_RESET_EN
    localparam logic [3:0] LAST_IDX = 4'd10;
`else
    localparam logic [3:0] LAST_IDX = 4'd9;
`endif

    typedef enum logic [2:0] {
        S_SETTLE, S_LOAD, S_SEND, S_WAIT, S_CHECK, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] cnt;
    logic [31:0] retry_cnt;
    logic        retry_pend;
    logic        ack_q;
    logic        rt_flag;
    logic [6:0]  wr_addr_q;
    logic [8:0]  wr_data_q;

    // Each word is {reg_addr[6:0], reg_data[8:0]}
    function automatic logic [15:0] table_word(input logic [3:0] idx);
        logic [15:0] w;
        case (idx)
`ifdef CODEC_CFG_SOFT_RESET_EN
            4'd0:    w = 16'h1E00;
            4'd1:    w = 16'h001A;
            4'd2:    w = 16'h021A;
            4'd3:    w = 16'h047B;
            4'd4:    w = 16'h067B;
            4'd5:    w = 16'h08F8;
            4'd6:    w = 16'h0A06;
            4'd7:    w = 16'h0C00;
            4'd8:    w = 16'h0E01;
            4'd9:    w = 16'h1002;
            4'd10:   w = 16'h1201;
`else
            4'd0:    w = 16'h001A;
            4'd1:    w = 16'h021A;
            4'd2:    w = 16'h047B;
            4'd3:    w = 16'h067B;
            4'd4:    w = 16'h08F8;
            4'd5:    w = 16'h0A06;
            4'd6:    w = 16'h0C00;
            4'd7:    w = 16'h0E01;
            4'd8:    w = 16'h1002;
            4'd9:    w = 16'h1201;
`endif
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= S_SETTLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_SETTLE: if (cnt == SETTLE_CYCLES) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_SEND;
            S_SEND:   state_nxt = S_WAIT;
            S_WAIT:   if (i_i2c_end || (cnt == TIMEOUT_CYCLES - 1)) state_nxt = S_CHECK;
            S_CHECK: begin
                if (ack_q || (retry_cnt < RETRY_MAX)) state_nxt = S_GAP;
                else                                  state_nxt = S_ERROR;
            end
            S_GAP: begin
                if (cnt == GAP_CYCLES) begin
                    if (retry_pend)                          state_nxt = S_LOAD;
                    else if (rt_flag || o_index == LAST_IDX) state_nxt = S_DONE;
                    else                                     state_nxt = S_LOAD;
                end
            end
            S_DONE: begin
                if (i_restart)       state_nxt = S_SETTLE;
                else if (i_wr_valid) state_nxt = S_LOAD;
            end
            S_ERROR:  if (i_restart) state_nxt = S_SETTLE;
            default:  state_nxt = S_SETTLE;
        endcase
    end

    // The shared counter restarts on every state change, so SETTLE, WAIT and GAP each begin at zero.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt           <= 32'd0;
            retry_cnt     <= 32'd0;
            retry_pend    <= 1'b0;
            ack_q         <= 1'b0;
            rt_flag       <= 1'b0;
            wr_addr_q     <= 7'd0;
            wr_data_q     <= 9'd0;
            o_i2c_data    <= 24'd0;
            o_config_done <= 1'b0;
            o_index       <= 4'd0;
        end else begin
            if (state_nxt != state || state == S_DONE || state == S_ERROR) cnt <= 32'd0;
            else                                                         cnt <= cnt + 32'd1;

            case (state)
                S_LOAD: begin
                    o_i2c_data <= {DEV_ADDR, rt_flag ? {wr_addr_q, wr_data_q} : table_word(o_index)};
                end
                S_WAIT: begin
                    if (i_i2c_end)                      ack_q <= i_i2c_ack;
                    else if (cnt == TIMEOUT_CYCLES - 1) ack_q <= 1'b0;
                end
                S_CHECK: begin
                    if (ack_q) begin
                        retry_cnt  <= 32'd0;
                        retry_pend <= 1'b0;
                    end else if (retry_cnt < RETRY_MAX) begin
                        retry_cnt  <= retry_cnt + 32'd1;
                        retry_pend <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_CYCLES && !retry_pend) begin
                        if (rt_flag || o_index == LAST_IDX) begin
                            o_config_done <= 1'b1;
                            rt_flag       <= 1'b0;
                        end else begin
                            o_index <= o_index + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    // Restart takes priority; a write arriving in the same cycle is dropped.
                    if (i_restart) begin
                        o_config_done <= 1'b0;
                        o_index       <= 4'd0;
                        retry_cnt     <= 32'd0;
                        retry_pend    <= 1'b0;
                    end else if (i_wr_valid) begin
                        wr_addr_q <= i_wr_addr;
                        wr_data_q <= i_wr_data;
                        rt_flag   <= 1'b1;
                    end
                end
                S_ERROR: begin
                    if (i_restart) begin
                        o_config_done <= 1'b0;
                        o_index       <= 4'd0;
                        retry_cnt     <= 32'd0;
                        retry_pend    <= 1'b0;
                        rt_flag       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_i2c_go   = (state == S_SEND);
        o_wr_ready = (state == S_DONE);
        o_error    = (state == S_ERROR);
        o_busy     = (state != S_DONE) && (state != S_ERROR);
    end

endmodule
